// File: rtl/seg7_bcd_reader.sv
// seg7_bcd_reader: receive-side monitor for a 3-digit active-low 7-segment bus.
// - Samples the three digit patterns and waits for a stable repeat.
// - Decodes each pattern back to a BCD digit.
// - Converts the 3-digit value to binary with a 3-cycle multiply-by-ten loop.
module seg7_bcd_reader #(
  parameter int STABLE_N = 2,   // consecutive identical samples before conversion (1..15)
  parameter int CNT_W    = 4    // stability counter width; must hold STABLE_N
) (
  input  logic        clk,
  input  logic        rst,        // synchronous, active-low
  input  logic        sample_en,
  input  logic [6:0]  seg0,       // units    {g,f,e,d,c,b,a}, active-low
  input  logic [6:0]  seg1,       // tens
  input  logic [6:0]  seg2,       // hundreds
  output logic [11:0] bcd_out,
  output logic [9:0]  bin_out,
  output logic        valid,
  output logic        err,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_N);
  localparam logic [20:0]      BLANK3   = 21'h1FFFFF;

  // Pattern -> {ok, digit}; anything outside the ten digit glyphs (blank included) is not ok.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    case (pat)
      7'b1000000: return {1'b1, 4'd0};
      7'b1111001: return {1'b1, 4'd1};
      7'b0100100: return {1'b1, 4'd2};
      7'b0110000: return {1'b1, 4'd3};
      7'b0011001: return {1'b1, 4'd4};
      7'b0010010: return {1'b1, 4'd5};
      7'b0000010: return {1'b1, 4'd6};
      7'b1111000: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0010000: return {1'b1, 4'd9};
      default:    return {1'b0, 4'd0};
    endcase
  endfunction

  logic [1:0]       state_q,    state_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [20:0]      snap_q,     snap_d;
  logic [20:0]      last_pub_q, last_pub_d;
  logic [11:0]      digits_q,   digits_d;   // decoded digits latched at qualification
  logic [9:0]       acc_q,      acc_d;
  logic [1:0]       idx_q,      idx_d;
  logic [11:0]      bcd_q,      bcd_d;
  logic [9:0]       bin_q,      bin_d;
  logic             valid_q,    valid_d;
  logic             err_q,      err_d;

  logic [20:0]      cur;
  logic [4:0]       dec2, dec1, dec0;
  logic             all_ok;
  logic [CNT_W-1:0] new_cnt;
  logic [3:0]       conv_digit;

  assign cur    = {seg2, seg1, seg0};
  assign dec2   = decode_seg(seg2);
  assign dec1   = decode_seg(seg1);
  assign dec0   = decode_seg(seg0);
  assign all_ok = dec2[4] & dec1[4] & dec0[4];

  // Digit consumed by the current conversion step, hundreds first.
  always_comb begin
    case (idx_q)
      2'd2:    conv_digit = digits_q[11:8];
      2'd1:    conv_digit = digits_q[7:4];
      default: conv_digit = digits_q[3:0];
    endcase
  end

  // Next-state logic: stability filter in IDLE, accumulate in CONV, publish in DONE.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    snap_d     = snap_q;
    last_pub_d = last_pub_q;
    digits_d   = digits_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    new_cnt    = stab_cnt_q;

    case (state_q)
      IDLE: begin
        if (sample_en) begin
          if (cur == snap_q) begin
            new_cnt = (stab_cnt_q >= STABLE_C) ? STABLE_C : stab_cnt_q + CNT_W'(1);
          end else begin
            snap_d  = cur;
            new_cnt = CNT_W'(1);
          end
          stab_cnt_d = new_cnt;
          // A display already published is not republished until something else passes.
          if (new_cnt == STABLE_C && cur != last_pub_q) begin
            last_pub_d = cur;
            if (!all_ok) begin
              err_d = 1'b1;
            end else begin
              digits_d = {dec2[3:0], dec1[3:0], dec0[3:0]};
              acc_d    = 10'd0;
              idx_d    = 2'd2;
              state_d  = CONV;
            end
          end
        end
      end
      CONV: begin
        acc_d = (acc_q << 3) + (acc_q << 1) + {6'd0, conv_digit};
        idx_d = idx_q - 2'd1;
        if (idx_q == 2'd0) state_d = DONE;
      end
      DONE: begin
        bin_d   = acc_q;
        bcd_d   = digits_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; reset abandons any conversion.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state_q    <= IDLE;
      stab_cnt_q <= '0;
      snap_q     <= BLANK3;
      last_pub_q <= BLANK3;
      digits_q   <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      bcd_q      <= '0;
      bin_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
      snap_q     <= snap_d;
      last_pub_q <= last_pub_d;
      digits_q   <= digits_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign bcd_out = bcd_q;
  assign bin_out = bin_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);

endmodule
